// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message padder.
//
// Contents:
//   - Word and block geometry, the padding marker byte and the word indices
//     that carry the 64-bit length field.
//   - sha_state_e: padder sequencing states.
//   - byteswap32: reverses the bytes of a 32-bit word. The length field is
//     big-endian, but lane 0 of each output word is the earliest byte.
package sha256_pkg;

  localparam int SHA_WORD_W      = 32;
  localparam int SHA_BLOCK_WORDS = 16;
  localparam int SHA_WI_W        = $clog2(SHA_BLOCK_WORDS);

  localparam logic [7:0]          SHA_PAD_BYTE  = 8'h80;
  localparam logic [SHA_WI_W-1:0] SHA_LEN_WI_HI = 4'd14;
  localparam logic [SHA_WI_W-1:0] SHA_LEN_WI_LO = 4'd15;

  // Last word index that can still hold zero fill. A marker or zero word
  // emitted here is followed directly by the length field.
  localparam logic [SHA_WI_W-1:0] SHA_ZERO_LAST_WI = SHA_LEN_WI_HI - 4'd1;

  typedef enum logic [2:0] {
    ST_DATA   = 3'd0,
    ST_MARK   = 3'd1,
    ST_ZERO   = 3'd2,
    ST_LEN_HI = 3'd3,
    ST_LEN_LO = 3'd4
  } sha_state_e;

  function automatic logic [31:0] byteswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sha256_padder.sv
// SHA-256 message padder.
//
// Takes a raw message as a stream of 32-bit beats and emits complete 512-bit
// blocks as 16 consecutive 32-bit words. Standard SHA-256 padding is applied:
// a 0x80 marker byte, zero fill, and the 64-bit big-endian message length in
// bits. Byte lane 0 (bits 7:0) of every word holds the earliest message byte.
//
// Ports:
//   aclk, aresetn   clock, asynchronous active-low reset
//   s_data          message bytes, lane 0 first
//   s_keep          valid byte lanes; used only on the last beat
//   s_last          final beat of the message
//   s_valid/s_ready input handshake
//   m_word          padded block word
//   m_valid/m_ready output handshake
//   m_block_last    marks word 15 of every block
//   m_msg_last      marks word 15 of the final block of the message
//   busy            message in progress (first beat accepted, final word
//                   not yet consumed)
//   dbg_state       current padder state, for observation only
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. A valid source holds its data and flags stable until that
// edge. Here m_valid never depends on m_ready, and s_ready depends on m_ready
// only through the output register being free.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_WIDTH = 64
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [SHA_WORD_W-1:0] s_data,
  input  logic [3:0]            s_keep,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [SHA_WORD_W-1:0] m_word,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_block_last,
  output logic                  m_msg_last,
  output logic                  busy,
  output sha_state_e            dbg_state
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  sha_state_e            state_q, state_d;
  logic [SHA_WI_W-1:0]   wi_q, wi_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  busy_q, busy_d;
  logic [SHA_WORD_W-1:0] m_word_q, m_word_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_block_last_q, m_block_last_d;
  logic                  m_msg_last_q, m_msg_last_d;

  // ---------------------------------------------------------------------------
  // Beat decode
  // ---------------------------------------------------------------------------
  logic                  out_load;
  logic                  beat_acc;
  logic [2:0]            last_bytes;
  logic [2:0]            beat_bytes;
  logic [SHA_WORD_W-1:0] last_word;
  logic [63:0]           len_ext;

  // The output register can take a new word when it is empty or its current
  // word is being consumed in this cycle.
  assign out_load = !m_valid_q || m_ready;

  // Gated by aresetn so no beat is offered as accepted while reset is held.
  assign s_ready  = aresetn && (state_q == ST_DATA) && out_load;
  assign beat_acc = s_valid && s_ready;

  // Byte count on the last beat follows the highest set keep bit, so holes in
  // the mask below it still count as message bytes.
  always_comb begin
    last_bytes = 3'd0;
    casez (s_keep)
      4'b1???: last_bytes = 3'd4;
      4'b01??: last_bytes = 3'd3;
      4'b001?: last_bytes = 3'd2;
      4'b0001: last_bytes = 3'd1;
      default: last_bytes = 3'd0;
    endcase
  end

  assign beat_bytes = s_last ? last_bytes : 3'd4;

  // Last-beat word: message lanes kept, the marker in the first unused lane,
  // zeros above it. With four bytes there is no free lane and the marker
  // goes out as a separate word.
  always_comb begin
    last_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < last_bytes) begin
        last_word[8*i +: 8] = s_data[8*i +: 8];
      end else if (3'(i) == last_bytes) begin
        last_word[8*i +: 8] = SHA_PAD_BYTE;
      end
    end
  end

  // Counter bits above LEN_WIDTH read as zero in the length field.
  assign len_ext = 64'(len_q);

  // ---------------------------------------------------------------------------
  // Next-state and output-register logic
  // ---------------------------------------------------------------------------
  logic                  emit;
  logic [SHA_WORD_W-1:0] emit_word;
  logic                  emit_msg_last;

  always_comb begin
    state_d        = state_q;
    wi_d           = wi_q;
    len_d          = len_q;
    busy_d         = busy_q;
    m_word_d       = m_word_q;
    m_valid_d      = m_valid_q;
    m_block_last_d = m_block_last_q;
    m_msg_last_d   = m_msg_last_q;
    emit           = 1'b0;
    emit_word      = '0;
    emit_msg_last  = 1'b0;

    // Current word consumed: the register empties unless refilled below.
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      if (m_msg_last_q) begin
        busy_d = 1'b0;
      end
    end

    // Every transition is tied to a load, so backpressure freezes the FSM.
    if (out_load) begin
      unique case (state_q)
        ST_DATA: begin
          if (beat_acc) begin
            emit   = 1'b1;
            busy_d = 1'b1;
            len_d  = len_q + LEN_WIDTH'({beat_bytes, 3'b000});
            if (s_last) begin
              emit_word = last_word;
              if (last_bytes == 3'd4) begin
                state_d = ST_MARK;
              end else if (wi_q == SHA_ZERO_LAST_WI) begin
                state_d = ST_LEN_HI;
              end else begin
                state_d = ST_ZERO;
              end
            end else begin
              emit_word = s_data;
            end
          end
        end

        ST_MARK: begin
          emit      = 1'b1;
          emit_word = {24'd0, SHA_PAD_BYTE};
          state_d   = (wi_q == SHA_ZERO_LAST_WI) ? ST_LEN_HI : ST_ZERO;
        end

        // A marker at word 14 or 15 leaves no room for the length, so zero
        // fill runs through the next block up to word 13.
        ST_ZERO: begin
          emit      = 1'b1;
          emit_word = '0;
          if (wi_q == SHA_ZERO_LAST_WI) begin
            state_d = ST_LEN_HI;
          end
        end

        ST_LEN_HI: begin
          emit      = 1'b1;
          emit_word = byteswap32(len_ext[63:32]);
          state_d   = ST_LEN_LO;
        end

        ST_LEN_LO: begin
          emit          = 1'b1;
          emit_word     = byteswap32(len_ext[31:0]);
          emit_msg_last = 1'b1;
          state_d       = ST_DATA;
          len_d         = '0;
        end

        default: begin
          state_d = ST_DATA;
        end
      endcase
    end

    if (emit) begin
      m_valid_d      = 1'b1;
      m_word_d       = emit_word;
      m_block_last_d = (wi_q == SHA_LEN_WI_LO);
      m_msg_last_d   = emit_msg_last;
      wi_d           = emit_msg_last ? '0 : wi_q + 4'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= ST_DATA;
      wi_q           <= '0;
      len_q          <= '0;
      busy_q         <= 1'b0;
      m_word_q       <= '0;
      m_valid_q      <= 1'b0;
      m_block_last_q <= 1'b0;
      m_msg_last_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      wi_q           <= wi_d;
      len_q          <= len_d;
      busy_q         <= busy_d;
      m_word_q       <= m_word_d;
      m_valid_q      <= m_valid_d;
      m_block_last_q <= m_block_last_d;
      m_msg_last_q   <= m_msg_last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign m_word       = m_word_q;
  assign m_valid      = m_valid_q;
  assign m_block_last = m_block_last_q;
  assign m_msg_last   = m_msg_last_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_sha256_padder.sv
`timescale 1ns/1ps
module tb_sha256_padder;
  import sha256_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_data = '0;
  logic [3:0]  s_keep = '0;
  logic        s_last = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] m_word;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_block_last;
  logic        m_msg_last;
  logic        busy;
  sha_state_e  dbg_state;

  always #5 aclk = ~aclk;

  sha256_padder #(.LEN_WIDTH(64)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_data       (s_data),
    .s_keep       (s_keep),
    .s_last       (s_last),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_word       (m_word),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_block_last (m_block_last),
    .m_msg_last   (m_msg_last),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic        exp_bl_q[$];
  logic        exp_ml_q[$];
  logic [31:0] got_w_q[$];
  logic        got_bl_q[$];
  logic        got_ml_q[$];
  logic        track_stall = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Block-last is expected on every sixteenth word of a message.
  task automatic push_exp(input logic [31:0] w, input logic ml);
    exp_bl_q.push_back((exp_q.size() % 16) == 15);
    exp_ml_q.push_back(ml);
    exp_q.push_back(w);
  endtask

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) push_exp(32'h0, 1'b0);
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(4 * i);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // Output monitor: sampled on the falling edge, a word is taken when the
  // handshake will complete on the following rising edge.
  always @(negedge aclk) begin
    if (aresetn && m_valid) begin
      if (track_stall && !m_ready) begin
        if (got_w_q.size() < exp_q.size()) begin
          check($sformatf("stall word %0d", got_w_q.size()), m_word, exp_q[got_w_q.size()]);
          check($sformatf("stall flags %0d", got_w_q.size()), {m_block_last, m_msg_last},
                {exp_bl_q[got_w_q.size()], exp_ml_q[got_w_q.size()]});
        end
        check("stall s_ready", s_ready, 1'b0);
      end
      if (m_ready) begin
        got_w_q.push_back(m_word);
        got_bl_q.push_back(m_block_last);
        got_ml_q.push_back(m_msg_last);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int waited = 0;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    s_valid = 1'b1;
    @(negedge aclk);
    while (!s_ready && waited < 1000) begin
      waited++;
      @(negedge aclk);
    end
    if (!s_ready) check("s_ready timeout", s_ready, 1'b1);
    @(posedge aclk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_keep  = '0;
    s_data  = '0;
  endtask

  task automatic finish_scn(input string name);
    int waited = 0;
    while (got_w_q.size() < exp_q.size() && waited < 3000) begin
      @(posedge aclk);
      waited++;
    end
    repeat (4) @(posedge aclk);
    #1;
    check({name, " count"}, got_w_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_w_q.size(); i++) begin
      check($sformatf("%s word %0d", name, i), got_w_q[i], exp_q[i]);
      check($sformatf("%s block_last %0d", name, i), got_bl_q[i], exp_bl_q[i]);
      check($sformatf("%s msg_last %0d", name, i), got_ml_q[i], exp_ml_q[i]);
    end
    check({name, " busy idle"}, busy, 1'b0);
    exp_q.delete();
    exp_bl_q.delete();
    exp_ml_q.delete();
    got_w_q.delete();
    got_bl_q.delete();
    got_ml_q.delete();
  endtask

  task automatic run_hello(input string name);
    push_exp(32'h6c6c6568, 1'b0);
    push_exp(32'h6f77206f, 1'b0);
    push_exp(32'h80646c72, 1'b0);
    push_zeros(12);
    push_exp(32'h58000000, 1'b1);
    send_beat(32'h6c6c6568, 4'b1111, 1'b0);
    check({name, " busy set"}, busy, 1'b1);
    send_beat(32'h6f77206f, 4'b1111, 1'b0);
    send_beat(32'h00646c72, 4'b0111, 1'b1);
    finish_scn(name);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    check("rst m_valid", m_valid, 1'b0);
    check("rst m_word", m_word, 32'h0);
    check("rst block_last", m_block_last, 1'b0);
    check("rst msg_last", m_msg_last, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst s_ready", s_ready, 1'b0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("idle s_ready", s_ready, 1'b1);
    check("idle state", dbg_state, ST_DATA);

    // "hello world"
    run_hello("hello");

    // Empty message: data on the beat is ignored entirely.
    push_exp(32'h00000080, 1'b0);
    push_zeros(14);
    push_exp(32'h00000000, 1'b1);
    send_beat(32'hdeadbeef, 4'b0000, 1'b1);
    finish_scn("empty");

    // 55 bytes: marker lands at word 13, length follows immediately.
    for (int i = 0; i < 13; i++) push_exp(pat(i), 1'b0);
    push_exp(32'h80363534, 1'b0);
    push_exp(32'h00000000, 1'b0);
    push_exp(32'hB8010000, 1'b1);
    for (int i = 0; i < 13; i++) send_beat(pat(i), 4'b0000, 1'b0);
    send_beat(32'hFF363534, 4'b0111, 1'b1);
    finish_scn("b55");

    // 56 bytes: marker word at 14, second block is padding only.
    for (int i = 0; i < 14; i++) push_exp(pat(i), 1'b0);
    push_exp(32'h00000080, 1'b0);
    push_exp(32'h00000000, 1'b0);
    push_zeros(14);
    push_exp(32'h00000000, 1'b0);
    push_exp(32'hC0010000, 1'b1);
    for (int i = 0; i < 13; i++) send_beat(pat(i), 4'b1111, 1'b0);
    send_beat(pat(13), 4'b1111, 1'b1);
    finish_scn("b56");

    // 64 bytes with consumer backpressure.
    for (int i = 0; i < 16; i++) push_exp(pat(i), 1'b0);
    push_exp(32'h00000080, 1'b0);
    push_zeros(13);
    push_exp(32'h00000000, 1'b0);
    push_exp(32'h00020000, 1'b1);
    track_stall = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) send_beat(pat(i), 4'b1111, i == 15);
      end
      begin
        int w;
        w = 0;
        while (got_w_q.size() < 7 && w < 2000) begin
          @(posedge aclk);
          #1;
          w++;
        end
        m_ready = 1'b0;
        repeat (5) begin
          @(posedge aclk);
          #1;
        end
        w = 0;
        while (got_w_q.size() < 32 && w < 2000) begin
          m_ready = 1'($urandom_range(0, 1));
          @(posedge aclk);
          #1;
          w++;
        end
        m_ready = 1'b1;
      end
    join
    finish_scn("b64");
    track_stall = 1'b0;

    // Reset in the middle of a message, word 9 sitting in the output register.
    for (int i = 0; i < 9; i++) push_exp(pat(i), 1'b0);
    for (int i = 0; i < 10; i++) send_beat(pat(i), 4'b1111, 1'b0);
    check("pre-rst busy", busy, 1'b1);
    #2;
    aresetn = 1'b0;
    #1;
    check("mid-rst m_valid", m_valid, 1'b0);
    check("mid-rst busy", busy, 1'b0);
    check("mid-rst s_ready", s_ready, 1'b0);
    check("mid-rst m_word", m_word, 32'h0);
    check("mid-rst state", dbg_state, ST_DATA);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    finish_scn("rst");

    run_hello("hello again");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
